// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch port and the load/store port.
// Accesses are serialised in order; data has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_owner_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_wait_cnt;
  logic [3:0]  r_starve;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic w_arb_en;
  logic w_d_elig;
  logic w_if_elig;
  logic w_starved;
  logic w_grant_d;
  logic w_grant_if;
  logic w_grant;

  // In DONE the port that just completed is excluded, so the other side gets a turn.
  always_comb begin
    w_arb_en   = (r_state == S_IDLE) || (r_state == S_DONE);
    w_d_elig   = d_req  && !((r_state == S_DONE) &&  r_owner_d);
    w_if_elig  = if_req && !((r_state == S_DONE) && !r_owner_d);
    w_starved  = w_if_elig && (r_starve == STARVE_LIM);
    w_grant_d  = w_arb_en && w_d_elig && !w_starved;
    w_grant_if = w_arb_en && w_if_elig && !w_grant_d;
    w_grant    = w_grant_d || w_grant_if;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_ce       = 1'b0;
    mem_we       = 1'b0;
    if_valid     = 1'b0;
    d_valid      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_state_next = S_ISSUE;
      S_ISSUE: begin
        mem_ce       = 1'b1;
        mem_we       = r_we;
        w_state_next = S_WAIT;
      end
      S_WAIT:  if (r_wait_cnt == 2'd0) w_state_next = S_DONE;
      S_DONE:  begin
        if_valid     = !r_owner_d;
        d_valid      =  r_owner_d;
        w_state_next = w_grant ? S_ISSUE : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_addr    <= w_grant_d ? d_addr : if_addr;
        r_we      <= w_grant_d && d_we;
      end
      if (w_grant_d) begin
        r_wdata <= d_wdata;
      end
      // Only data grants made while fetch is waiting count towards starvation.
      if (w_grant_if) begin
        r_starve <= '0;
      end else if (w_grant_d && if_req && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + 4'd1;
      end
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= WAIT_INIT;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 2'd0)) begin
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end
      if ((r_state == S_WAIT) && (r_wait_cnt == 2'd0) && !r_we) begin
        if (r_owner_d) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  // Stalls are held low while reset is asserted so every output reads 0 in reset.
  assign if_stall  = rst && if_req && !if_valid;
  assign d_stall   = rst && d_req  && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: MEM_LAT=1 instance for the main traffic, MEM_LAT=3 instance for reset abort.
module tb_mem_port_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:1023];

  logic        a_rst, a_if_req, a_if_valid, a_if_stall, a_d_req, a_d_we, a_d_valid, a_d_stall;
  logic        a_mem_ce, a_mem_we;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_rst, b_if_req, b_if_valid, b_if_stall, b_d_req, b_d_we, b_d_valid, b_d_stall;
  logic        b_mem_ce, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_p1, b_p2;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
    .if_valid(a_if_valid), .if_stall(a_if_stall),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_valid(a_d_valid), .d_stall(a_d_stall),
    .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_valid(b_if_valid), .if_stall(b_if_stall),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid), .d_stall(b_d_stall),
    .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory shared by both instances; only instance A writes.
  always @(posedge clk) begin
    if (a_mem_ce) begin
      if (a_mem_we) mem[a_mem_addr[11:2]] <= a_mem_wdata;
      else          a_mem_rdata <= mem[a_mem_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (b_mem_ce) b_p1 <= mem[b_mem_addr[11:2]];
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    mem[4]   <= 32'h0000_0013;
    mem[8]   <= 32'h0010_0093;
    mem[9]   <= 32'h0020_0113;
    mem[16]  <= 32'hCAFE_F00D;
    mem[17]  <= 32'h1234_5678;
    mem[64]  <= 32'h1111_1111;
    mem[65]  <= 32'h2222_2222;
    mem[66]  <= 32'h3333_3333;
    mem[67]  <= 32'h4444_4444;
    mem[68]  <= 32'h5555_5555;
    mem[69]  <= 32'h6666_6666;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Lets outstanding requests on instance A finish, dropping each on its completion pulse.
  task automatic drain(input string name);
    int c;
    c = 0;
    while ((a_if_req || a_d_req) && (c < 60)) begin
      @(negedge clk);
      if (a_d_valid)  a_d_req  = 1'b0;
      if (a_if_valid) a_if_req = 1'b0;
      c++;
    end
    chk1({name, "_timeout"}, a_if_req | a_d_req, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor for instance A completions.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (a_if_valid || a_d_valid) begin
      checks++;
      if (a_if_valid && a_d_valid) begin
        errors++;
        $display("FAIL mon_onehot: if_valid=1 d_valid=1, expected only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: port=%s data=%h, expected no completion",
                 a_d_valid ? "D" : "F", a_d_valid ? a_d_rdata : a_if_rdata);
      end else begin
        e = exp_q.pop_front();
        if ((e.is_d !== a_d_valid) || ((a_d_valid ? a_d_rdata : a_if_rdata) !== e.data)) begin
          errors++;
          $display("FAIL mon_txn: port=%s data=%h, expected port=%s data=%h",
                   a_d_valid ? "D" : "F", a_d_valid ? a_d_rdata : a_if_rdata,
                   e.is_d ? "D" : "F", e.data);
        end else begin
          $display("txn port=%s data=%h t=%0t", e.is_d ? "D" : "F", e.data, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int we_cnt;
    logic fetch_done;

    a_rst = 1'b0; b_rst = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100; a_d_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0;

    // Reset held with both requests pending.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ctrl", {26'd0, a_mem_ce, a_mem_we, a_if_valid, a_d_valid, a_if_stall, a_d_stall}, 32'h0);
      chk("rst_mem_addr", a_mem_addr, 32'h0);
      chk("rst_mem_wdata", a_mem_wdata, 32'h0);
      chk("rst_if_rdata", a_if_rdata, 32'h0);
      chk("rst_d_rdata", a_d_rdata, 32'h0);
    end
    a_rst = 1'b1; b_rst = 1'b1;
    push_exp(1'b1, 32'h1111_1111);
    push_exp(1'b0, 32'h0010_0093);
    @(negedge clk);
    chk1("rel_mem_ce", a_mem_ce, 1'b1);
    chk("rel_mem_addr", a_mem_addr, 32'h100);
    drain("rel");

    // Single fetch, MEM_LAT=1.
    a_if_req = 1'b1; a_if_addr = 32'h10;
    push_exp(1'b0, 32'h0000_0013);
    #1 chk1("f_stall_c0", a_if_stall, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk1($sformatf("f_ce_c%0d", c), a_mem_ce, c == 1);
      chk1($sformatf("f_valid_c%0d", c), a_if_valid, c == 3);
      chk1($sformatf("f_stall_c%0d", c), a_if_stall, c != 3);
      if (c == 1) begin
        chk("f_addr_c1", a_mem_addr, 32'h10);
        chk1("f_we_c1", a_mem_we, 1'b0);
      end
      if (c == 3) begin
        chk("f_rdata_c3", a_if_rdata, 32'h0000_0013);
        a_if_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // Simultaneous fetch and load: data first, fetch back-to-back.
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    push_exp(1'b1, 32'h1111_1111);
    push_exp(1'b0, 32'h0010_0093);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk1($sformatf("sim_ce_c%0d", c), a_mem_ce, (c == 1) || (c == 4));
      chk1($sformatf("sim_dv_c%0d", c), a_d_valid, c == 3);
      chk1($sformatf("sim_iv_c%0d", c), a_if_valid, c == 6);
      if (c == 1) chk("sim_addr_c1", a_mem_addr, 32'h100);
      if (c == 4) chk("sim_addr_c4", a_mem_addr, 32'h20);
      if (a_d_valid)  a_d_req  = 1'b0;
      if (a_if_valid) a_if_req = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Starvation: fetch pending at every IDLE arbitration, withdrawn only while data completes.
    push_exp(1'b1, 32'h2222_2222);
    push_exp(1'b1, 32'h3333_3333);
    push_exp(1'b1, 32'h4444_4444);
    push_exp(1'b1, 32'h5555_5555);
    push_exp(1'b0, 32'h0020_0113);
    push_exp(1'b1, 32'h6666_6666);
    k = 0; fetch_done = 1'b0;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h104;
    a_if_req = 1'b1; a_if_addr = 32'h24;
    for (int c = 0; (c < 200) && (a_d_req || a_if_req); c++) begin
      @(negedge clk);
      if (a_if_valid) begin
        fetch_done = 1'b1;
        a_if_req   = 1'b0;
      end
      if (a_d_valid) begin
        k++;
        if (k < 5) a_d_addr = 32'h104 + 32'(4 * k);
        else       a_d_req  = 1'b0;
      end
      if (!fetch_done) a_if_req = !a_d_valid;
    end
    chk1("starve_timeout", a_d_req | a_if_req, 1'b0);
    chk("starve_data_cnt", 32'(k), 32'd5);
    repeat (2) @(negedge clk);

    // Counter cleared by the fetch grant: data wins a fresh simultaneous request.
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_d_req = 1'b1; a_d_addr = 32'h100;
    push_exp(1'b1, 32'h1111_1111);
    push_exp(1'b0, 32'h0010_0093);
    @(negedge clk);
    chk("post_starve_addr", a_mem_addr, 32'h100);
    drain("post_starve");

    // Store.
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h200; a_d_wdata = 32'hDEAD_BEEF;
    push_exp(1'b1, 32'h1111_1111);
    we_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (a_mem_we) we_cnt++;
      if (c == 1) begin
        chk1("st_ce_c1", a_mem_ce, 1'b1);
        chk1("st_we_c1", a_mem_we, 1'b1);
        chk("st_addr_c1", a_mem_addr, 32'h200);
        chk("st_wdata_c1", a_mem_wdata, 32'hDEAD_BEEF);
      end
      chk1($sformatf("st_dv_c%0d", c), a_d_valid, c == 3);
      if (a_d_valid) begin
        a_d_req = 1'b0;
        a_d_we  = 1'b0;
      end
    end
    chk("st_we_cycles", 32'(we_cnt), 32'd1);
    chk("st_mem_word", mem[128], 32'hDEAD_BEEF);
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h200;
    push_exp(1'b1, 32'hDEAD_BEEF);
    drain("ld_back");

    // MEM_LAT=3: reset during WAIT aborts the fetch.
    b_if_req = 1'b1; b_if_addr = 32'h40;
    @(negedge clk);
    chk1("b_ce_c1", b_mem_ce, 1'b1);
    @(negedge clk);
    b_rst = 1'b0; b_if_req = 1'b0;
    @(negedge clk);
    chk("b_abort_ctrl", {27'd0, b_mem_ce, b_mem_we, b_if_valid, b_if_stall, b_d_valid}, 32'h0);
    chk("b_abort_addr", b_mem_addr, 32'h0);
    chk("b_abort_rdata", b_if_rdata, 32'h0);
    b_rst = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk);
      chk1($sformatf("b_nopulse_c%0d", c), b_if_valid, 1'b0);
      chk1($sformatf("b_idle_ce_c%0d", c), b_mem_ce, 1'b0);
    end
    b_if_req = 1'b1; b_if_addr = 32'h44;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk1($sformatf("b_ce_c%0d", c), b_mem_ce, c == 1);
      chk1($sformatf("b_iv_c%0d", c), b_if_valid, c == 5);
      if (c == 1) chk("b_addr_c1", b_mem_addr, 32'h44);
      if (c == 5) begin
        chk("b_rdata_c5", b_if_rdata, 32'h1234_5678);
        b_if_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
